// File: rtl/instr_pack.sv
// Shared types for the instruction sequencer: control states and defaults.
// No logic; imported by the sequencer top.
package instr_pack;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEMW  = 3'd3,
        S_HALT  = 3'd4
    } seq_state_t;

    localparam int WAIT_MAX_DEFAULT = 15;
    localparam int IR_W             = 9;
    localparam int RET_W            = 16;

endpackage

// File: rtl/instr_sequencer_pc_unit.sv
// Program counter: clear to 0, advance by +1 (wrapping) or load a branch target.
// Registered, one-cycle update; no backpressure.
module pc_unit #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_clr,
    input  logic            pc_adv,
    input  logic            pc_br,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (pc_clr) begin
            pc_d = '0;
        end else if (pc_adv) begin
            pc_d = pc_br ? br_target : pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute/memory-wait sequencer; fetch takes one cycle, non-memory ops retire in EXEC.
// Memory ops stall in MEMW until mem_ready, faulting to HALT after WAIT_MAX unanswered cycles.
module instr_sequencer
    import instr_pack::*;
#(
    parameter int PC_W     = 10,
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IR_W-1:0]  imem_data,
    input  logic             done,
    input  logic             load_en,
    input  logic             stor_en,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    input  logic             mem_ready,
    output logic [PC_W-1:0]  imem_addr,
    output logic [IR_W-1:0]  ir,
    output logic             mem_req,
    output logic             reg_we,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [RET_W-1:0] retired
);

    localparam int WCNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_MAX - 1);

    seq_state_t        state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [RET_W-1:0]  ret_q, ret_d;
    logic              fault_q, fault_d;
    logic              mem_req_q, mem_req_d;
    logic              is_load_q, is_load_d;
    logic              pc_clr, pc_adv, pc_br, retire;

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        wcnt_d    = wcnt_q;
        ret_d     = ret_q;
        fault_d   = fault_q;
        mem_req_d = mem_req_q;
        is_load_d = is_load_q;
        reg_we    = 1'b0;
        pc_clr    = 1'b0;
        pc_adv    = 1'b0;
        pc_br     = 1'b0;
        retire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_clr  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = imem_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (done) begin
                    state_d = S_HALT;
                end else if (load_en || stor_en) begin
                    // Load wins when both flags are set.
                    mem_req_d = 1'b1;
                    wcnt_d    = '0;
                    is_load_d = load_en;
                    state_d   = S_MEMW;
                end else begin
                    reg_we  = 1'b1;
                    pc_adv  = 1'b1;
                    pc_br   = br_taken;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMW: begin
                // A ready on the last permitted cycle still completes the access.
                if (mem_ready) begin
                    reg_we    = is_load_q;
                    pc_adv    = 1'b1;
                    retire    = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_FETCH;
                end else if (wcnt_q == WCNT_LAST) begin
                    wcnt_d    = WCNT_W'(WAIT_MAX);
                    fault_d   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_HALT;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            S_HALT: begin
                if (start) begin
                    pc_clr  = 1'b1;
                    fault_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (retire && (ret_q != {RET_W{1'b1}})) begin
            ret_d = ret_q + RET_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            wcnt_q    <= '0;
            ret_q     <= '0;
            fault_q   <= 1'b0;
            mem_req_q <= 1'b0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wcnt_q    <= wcnt_d;
            ret_q     <= ret_d;
            fault_q   <= fault_d;
            mem_req_q <= mem_req_d;
            is_load_q <= is_load_d;
        end
    end

    pc_unit #(
        .PC_W(PC_W)
    ) u_pc (
        .clk       (clk),
        .rst       (reset),
        .pc_clr    (pc_clr),
        .pc_adv    (pc_adv),
        .pc_br     (pc_br),
        .br_target (br_target),
        .pc        (imem_addr)
    );

    assign ir      = ir_q;
    assign mem_req = mem_req_q;
    assign fault   = fault_q;
    assign retired = ret_q;
    assign busy    = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEMW);
    assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus random instruction streams
// checked against an instruction-level model of pc, retired count and status.
module tb_instr_sequencer;

    localparam int PC_W     = 10;
    localparam int WAIT_MAX = 15;
    localparam int PC_MOD   = 1 << PC_W;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_BOTH  = 3;
    localparam int K_DONE  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [8:0]      imem_data;
    logic            done, load_en, stor_en, br_taken;
    logic [PC_W-1:0] br_target;
    logic            mem_ready;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      ir;
    logic            mem_req, reg_we, busy, halted, fault;
    logic [15:0]     retired;

    logic [8:0] imem [0:PC_MOD-1];

    int n_chk  = 0;
    int n_fail = 0;

    // Instruction-level reference state.
    int m_pc   = 0;
    int m_ret  = 0;
    bit m_halt = 0;
    bit m_flt  = 0;

    instr_sequencer #(
        .PC_W     (PC_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .imem_data (imem_data),
        .done      (done),
        .load_en   (load_en),
        .stor_en   (stor_en),
        .br_taken  (br_taken),
        .br_target (br_target),
        .mem_ready (mem_ready),
        .imem_addr (imem_addr),
        .ir        (ir),
        .mem_req   (mem_req),
        .reg_we    (reg_we),
        .busy      (busy),
        .halted    (halted),
        .fault     (fault),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ret_inc();
        if (m_ret < 65535) m_ret++;
    endtask

    task automatic clear_inputs();
        start     = 1'b0;
        done      = 1'b0;
        load_en   = 1'b0;
        stor_en   = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        mem_ready = 1'b0;
    endtask

    // Entry: at a negedge with the DUT in IDLE or HALT.
    task automatic do_start();
        start = 1'b1;
        #1 chk("pre_start_busy", busy, 0);
        @(negedge clk);
        start  = 1'b0;
        m_pc   = 0;
        m_halt = 0;
        m_flt  = 0;
        chk("start_addr", imem_addr, 0);
        chk("start_fault", fault, 0);
        chk("start_busy", busy, 1);
        chk("start_retired", retired, m_ret);
    endtask

    // Entry: at a negedge with the DUT in FETCH. wait_n = 0 means mem_ready never comes.
    task automatic run_instr(input int kind, input bit brt, input logic [PC_W-1:0] tgt,
                             input int wait_n);
        bit is_ld;
        int mr_cnt;
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_busy", busy, 1);
        chk("fetch_halted", halted, 0);
        start     = 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
        #1 chk("fetch_reg_we", reg_we, 0);
        @(negedge clk);
        start     = 1'b0;
        mem_ready = 1'b0;
        chk("exec_ir", ir, imem[m_pc]);
        chk("exec_mem_req", mem_req, 0);
        done      = (kind == K_DONE);
        load_en   = (kind == K_LOAD) || (kind == K_BOTH);
        stor_en   = (kind == K_STORE) || (kind == K_BOTH);
        br_taken  = brt;
        br_target = tgt;
        if (kind == K_DONE) begin
            load_en  = 1'($urandom_range(0, 1));
            stor_en  = 1'($urandom_range(0, 1));
            br_taken = 1'($urandom_range(0, 1));
        end
        start = 1'($urandom_range(0, 1));
        #1 chk("exec_reg_we", reg_we, (kind == K_ALU));
        @(negedge clk);
        clear_inputs();
        if (kind == K_ALU) begin
            m_pc = brt ? int'(tgt) : (m_pc + 1) % PC_MOD;
            ret_inc();
        end else if (kind == K_DONE) begin
            m_halt = 1;
            chk("done_halted", halted, 1);
            chk("done_busy", busy, 0);
            chk("done_addr", imem_addr, m_pc);
            chk("done_reg_we", reg_we, 0);
        end else begin
            is_ld  = (kind != K_STORE);
            mr_cnt = 0;
            for (int i = 1; i <= WAIT_MAX; i++) begin
                if (mem_req === 1'b1) mr_cnt++;
                mem_ready = (i == wait_n);
                #1 chk("memw_reg_we", reg_we, is_ld && (i == wait_n));
                @(negedge clk);
                mem_ready = 1'b0;
                if (i == wait_n) break;
            end
            chk("memw_req_cycles", mr_cnt, (wait_n == 0) ? WAIT_MAX : wait_n);
            chk("memw_req_after", mem_req, 0);
            if (wait_n == 0) begin
                m_halt = 1;
                m_flt  = 1;
                chk("timeout_halted", halted, 1);
                chk("timeout_busy", busy, 0);
                chk("timeout_addr", imem_addr, m_pc);
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
                ret_inc();
            end
        end
        chk("retired", retired, m_ret);
        chk("fault", fault, m_flt);
    endtask

    initial begin
        int r;
        int w;
        for (int a = 0; a < PC_MOD; a++) imem[a] = 9'($urandom);
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_addr", imem_addr, 0);
        chk("rst_ir", ir, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_retired", retired, 0);
        reset = 1'b0;

        // Without start the sequencer stays idle.
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_addr", imem_addr, 0);
        chk("idle_halted", halted, 0);

        // Three straight-line instructions, then a taken branch.
        do_start();
        repeat (3) run_instr(K_ALU, 0, '0, 0);
        chk("three_retired", retired, 3);
        chk("three_addr", imem_addr, 3);
        run_instr(K_ALU, 1, 10'h155, 0);
        chk("branch_addr", imem_addr, 10'h155);

        // Load and store answered on the fourth wait cycle, then both flags together.
        run_instr(K_LOAD, 0, '0, 4);
        run_instr(K_STORE, 0, '0, 4);
        run_instr(K_BOTH, 0, '0, 2);
        // Ready on the final permitted cycle completes rather than faults.
        run_instr(K_LOAD, 0, '0, WAIT_MAX);

        // Wrap from the top address.
        run_instr(K_ALU, 1, 10'h3FF, 0);
        run_instr(K_ALU, 0, '0, 0);
        chk("wrap_addr", imem_addr, 0);
        run_instr(K_DONE, 0, '0, 0);
        repeat (2) @(negedge clk);
        chk("halt_stays", halted, 1);

        // Unanswered memory access faults, start clears it.
        do_start();
        run_instr(K_ALU, 0, '0, 0);
        run_instr(K_STORE, 0, '0, 0);
        chk("fault_set", fault, 1);
        do_start();

        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                run_instr(K_ALU, ($urandom_range(0, 9) < 3), PC_W'($urandom), 0);
            end else if (r < 80) begin
                w = (r < 50) ? WAIT_MAX : $urandom_range(1, WAIT_MAX);
                run_instr($urandom_range(K_LOAD, K_BOTH), 0, '0, w);
            end else if (r < 88) begin
                run_instr($urandom_range(K_LOAD, K_BOTH), 0, '0, 0);
            end else begin
                run_instr(K_DONE, 0, '0, 0);
            end
            if (m_halt) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                chk("rand_halted", halted, 1);
                do_start();
            end
        end

        // Reset mid-MEMW takes effect before the next clock edge.
        run_instr(K_ALU, 0, '0, 0);
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        chk("memw_req_on", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_busy", busy, 0);
        chk("async_halted", halted, 0);
        chk("async_fault", fault, 0);
        chk("async_reg_we", reg_we, 0);
        chk("async_addr", imem_addr, 0);
        chk("async_ir", ir, 0);
        chk("async_retired", retired, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 10, program counter width.
REQ-002 SHALL have parameter WAIT_MAX, default 15, maximum data-memory wait cycles before fault.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begins execution from address 0 when in IDLE or HALT.
REQ-006 SHALL have port imem_data  input  9  instruction word at imem_addr, combinational read.
REQ-007 SHALL have port done, load_en, stor_en  input  1 each  decoder flags for the instruction in ir.
REQ-008 SHALL have port br_taken  input  1  branch/jump resolved taken for the instruction in ir.
REQ-009 SHALL have port br_target  input  PC_W  next pc when br_taken.
REQ-010 SHALL have port mem_ready  input  1  data-memory access complete.
REQ-011 SHALL have port imem_addr  output  PC_W  equals pc.
REQ-012 SHALL have port ir  output  9  latched instruction, fed to decoder.
REQ-013 SHALL have port mem_req  output  1  data-memory request, held until mem_ready.
REQ-014 SHALL have port reg_we  output  1  one-cycle commit strobe for register-file write.
REQ-015 SHALL have ports busy, halted, fault  output  1 each  status.
REQ-016 SHALL have port retired  output  16  retired-instruction count.

Function
REQ-017 SHALL implement states IDLE, FETCH, EXEC, MEMW, HALT.
REQ-018 IDLE: start=1 -> pc<=0, next FETCH; otherwise stay.
REQ-019 FETCH: ir<=imem_data; next EXEC; fetch latency exactly one cycle.
REQ-020 EXEC, done=1: next HALT; pc unchanged; no reg_we; done takes priority over all other flags.
REQ-021 EXEC, load_en or stor_en: mem_req=1 from the next cycle; next MEMW; wait counter cleared.
REQ-022 EXEC, otherwise: reg_we=1 this cycle; pc<=br_taken ? br_target : pc+1; retired+1; next FETCH.
REQ-023 MEMW: mem_req=1 each cycle until mem_ready=1; on mem_ready: reg_we=1 only if the latched op was a load, pc<=pc+1, retired+1, mem_req low next cycle, next FETCH.
REQ-024 MEMW: wait counter increments per cycle without mem_ready; on reaching WAIT_MAX: fault<=1, mem_req deasserted, next HALT.
REQ-025 mem_ready in the same cycle the counter reaches WAIT_MAX SHALL count as completion, not fault.
REQ-026 HALT: halted=1; start=1 -> pc<=0, fault<=0, next FETCH; retired is preserved.
REQ-027 start SHALL be ignored in FETCH, EXEC and MEMW.
REQ-028 pc+1 SHALL wrap modulo 2^PC_W (max -> 0) with no status change.
REQ-029 retired SHALL saturate at 16'hFFFF.
REQ-030 busy=1 in FETCH, EXEC and MEMW; 0 in IDLE and HALT.
REQ-031 mem_ready outside MEMW SHALL be ignored.
REQ-032 load_en and stor_en together SHALL be treated as a load.

Reset
REQ-033 reset=1 SHALL immediately force state=IDLE, pc=0, ir=0, wait counter=0, retired=0, fault=0, mem_req=0, reg_we=0, busy=0, halted=0, including mid-MEMW.
REQ-034 After reset deasserts, the first state change SHALL require start=1.

Structure
REQ-035 The state enum seq_state_t and the default WAIT_MAX SHALL reside in instr_pack.
REQ-036 PC register, increment/wrap and branch mux SHALL be one sub-module pc_unit; the rest stays flat.

Verification
REQ-037 Reset, start=1 one cycle, three non-memory instructions -> imem_addr 0,1,2,3; reg_we pulses in each EXEC; retired=3.
REQ-038 EXEC with br_taken=1, br_target=10'h155 -> next imem_addr=10'h155; retired+1.
REQ-039 Load with mem_ready after 4 cycles -> mem_req high 4 cycles, one reg_we, pc+1; store with the same timing -> no reg_we.
REQ-040 Memory op with mem_ready never asserted -> fault=1, halted=1 after WAIT_MAX cycles; start -> fault=0, pc=0.
REQ-041 pc=10'h3FF non-branch -> pc=0; done=1 -> halted=1, busy=0; start during EXEC ignored.
REQ-042 reset asserted mid-MEMW -> all outputs at reset values asynchronously, before the next clock edge.
